// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions used by the instruction-cache refill engine.
package cpu_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned MEM_LAT        = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_READ,
    ST_DONE
  } refill_state_t;

endpackage

// File: rtl/icache_refill_if.sv
// Fetch request/response, byte memory port and cache write port of the refill engine.
interface icache_refill_if;
  import cpu_pkg::*;

  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] resp_inst;
  logic            mem_req;
  logic            mem_gnt;
  logic [XLEN-1:0] mem_a;
  logic [7:0]      mem_din;
  logic            cache_we;
  logic [XLEN-1:0] cache_addr;
  logic [XLEN-1:0] cache_data;

  // master: the refill engine; slave: fetch, arbiter/memory and cache around it
  modport master (
    input  req_valid, req_addr, mem_gnt, mem_din,
    output req_ready, resp_valid, resp_inst, mem_req, mem_a,
           cache_we, cache_addr, cache_data
  );

  modport slave (
    output req_valid, req_addr, mem_gnt, mem_din,
    input  req_ready, resp_valid, resp_inst, mem_req, mem_a,
           cache_we, cache_addr, cache_data
  );

endinterface

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: fetches a word byte-by-byte from the shared
// memory port, writes it into the cache and returns it to fetch.
module icache_refill #(
  parameter int unsigned MEM_LAT = cpu_pkg::MEM_LAT
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            clear_in,
  icache_refill_if.master bus
);
  import cpu_pkg::*;

  localparam int unsigned       CNT_W    = 3;
  localparam logic [CNT_W-1:0]  LAT_CNT  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BYTES_PER_WORD - 1 + MEM_LAT);
  localparam logic [CNT_W-1:0]  SAT_CNT  = CNT_W'(BYTES_PER_WORD - 2);
  localparam logic [1:0]        LAST_K   = 2'(BYTES_PER_WORD - 1);

  refill_state_t    r_state;
  logic [XLEN-1:0]  r_base;
  logic [XLEN-1:0]  r_asm;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_mem_req;
  logic [XLEN-1:0]  r_mem_a;
  logic             r_cache_we;
  logic             r_resp_valid;
  logic [XLEN-1:0]  r_cache_addr;
  logic [XLEN-1:0]  r_word;

  logic [1:0]       w_byte_idx;
  logic [1:0]       w_next_k;
  logic [XLEN-1:0]  w_asm_next;

  // r_cnt counts READ cycles; the byte landing now was addressed MEM_LAT cycles ago
  assign w_byte_idx = 2'(r_cnt - LAT_CNT);
  assign w_next_k   = (r_cnt >= SAT_CNT) ? LAST_K : 2'(r_cnt + 1'b1);

  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{w_byte_idx, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_asm        <= '0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_mem_req    <= 1'b0;
      r_mem_a      <= '0;
      r_cache_we   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_cache_addr <= '0;
      r_word       <= '0;
    end else if (!rdy_in) begin
      // a stall during READ throws away partial bytes and re-issues from byte 0
      if (r_state == ST_READ) begin
        r_cnt   <= '0;
        r_asm   <= '0;
        r_mem_a <= r_base;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.req_valid && !clear_in) begin
            r_base      <= bus.req_addr & ~32'h3;
            r_state     <= ST_WAIT_GNT;
            r_req_ready <= 1'b0;
            r_mem_req   <= 1'b1;
          end
        end

        ST_WAIT_GNT: begin
          if (clear_in) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_a     <= '0;
          end else if (bus.mem_gnt) begin
            r_state <= ST_READ;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_mem_a <= r_base;
          end
        end

        ST_READ: begin
          if (clear_in) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_a     <= '0;
            r_cnt       <= '0;
            r_asm       <= '0;
          end else begin
            if (r_cnt >= LAT_CNT) begin
              r_asm <= w_asm_next;
            end
            if (r_cnt == LAST_CNT) begin
              r_state      <= ST_DONE;
              r_word       <= w_asm_next;
              r_cache_addr <= r_base;
              r_cache_we   <= 1'b1;
              r_resp_valid <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_mem_a <= {r_base[XLEN-1:2], w_next_k};
            end
          end
        end

        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_mem_req    <= 1'b0;
          r_mem_a      <= '0;
          r_cnt        <= '0;
          r_cache_we   <= 1'b0;
          r_resp_valid <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // the pulses are masked while frozen; a flush in DONE still writes the cache
  assign bus.cache_we   = r_cache_we & rdy_in;
  assign bus.resp_valid = r_resp_valid & rdy_in & ~clear_in;
  assign bus.req_ready  = r_req_ready;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_a      = r_mem_a;
  assign bus.cache_addr = r_cache_addr;
  assign bus.cache_data = r_word;
  assign bus.resp_inst  = r_word;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill with a one-cycle-latency byte memory model.
module tb_icache_refill;

  logic clk;
  logic rst_in;
  logic rdy;
  logic clr;
  int   n_vec;
  int   n_err;
  int   we_cnt;
  int   rv_cnt;
  int   we_snap;
  int   rv_snap;

  icache_refill_if bus ();

  icache_refill #(.MEM_LAT(1)) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy),
    .clear_in (clr),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h1004: ram_byte = 8'h13;
      32'h1005: ram_byte = 8'h05;
      32'h1006: ram_byte = 8'h10;
      32'h1007: ram_byte = 8'h00;
      default:  ram_byte = a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk) bus.mem_din <= ram_byte(bus.mem_a);

  always @(negedge clk) begin
    if (bus.cache_we)   we_cnt <= we_cnt + 1;
    if (bus.resp_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    #1 rst_in = 1'b0;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    n_vec++; if (bus.mem_a !== 32'h0) begin n_err++; $display("FAIL rst_mem_a: got %h want 0", bus.mem_a); end
    n_vec++; if (bus.cache_we !== 1'b0) begin n_err++; $display("FAIL rst_cache_we: got %b want 0", bus.cache_we); end
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_vec++; if (bus.cache_data !== 32'h0) begin n_err++; $display("FAIL rst_cache_data: got %h want 0", bus.cache_data); end
    n_vec++; if (bus.cache_addr !== 32'h0) begin n_err++; $display("FAIL rst_cache_addr: got %h want 0", bus.cache_addr); end
    tick();
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_immediate_grant();
    bus.req_valid = 1'b1; bus.req_addr = 32'h1004;
    tick();
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    #1;
    n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL ig_mem_req: got %b want 1", bus.mem_req); end
    n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL ig_req_ready: got %b want 0", bus.req_ready); end
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      n_vec++; if (bus.mem_a !== 32'h1004 + 32'(k)) begin n_err++; $display("FAIL ig_mem_a%0d: got %h want %h", k, bus.mem_a, 32'h1004 + 32'(k)); end
    end
    tick(); #1;
    n_vec++; if (bus.cache_we !== 1'b0) begin n_err++; $display("FAIL ig_early_we: got %b want 0", bus.cache_we); end
    tick(); #1;
    n_vec++; if (bus.cache_we !== 1'b1) begin n_err++; $display("FAIL ig_cache_we: got %b want 1", bus.cache_we); end
    n_vec++; if (bus.cache_addr !== 32'h1004) begin n_err++; $display("FAIL ig_cache_addr: got %h want 00001004", bus.cache_addr); end
    n_vec++; if (bus.cache_data !== 32'h00100513) begin n_err++; $display("FAIL ig_cache_data: got %h want 00100513", bus.cache_data); end
    n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL ig_resp_valid: got %b want 1", bus.resp_valid); end
    n_vec++; if (bus.resp_inst !== 32'h00100513) begin n_err++; $display("FAIL ig_resp_inst: got %h want 00100513", bus.resp_inst); end
    tick(); #1;
    bus.mem_gnt = 1'b0;
    n_vec++; if (bus.cache_we !== 1'b0) begin n_err++; $display("FAIL ig_we_pulse: got %b want 0", bus.cache_we); end
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL ig_resp_pulse: got %b want 0", bus.resp_valid); end
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL ig_idle_ready: got %b want 1", bus.req_ready); end
    n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL ig_idle_mem_req: got %b want 0", bus.mem_req); end
  endtask

  task automatic test_grant_wait();
    bus.req_valid = 1'b1; bus.req_addr = 32'h1004;
    tick();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL gw_mem_req%0d: got %b want 1", c, bus.mem_req); end
      n_vec++; if (bus.mem_a !== 32'h0) begin n_err++; $display("FAIL gw_mem_a%0d: got %h want 0", c, bus.mem_a); end
      tick();
    end
    bus.mem_gnt = 1'b1;
    repeat (5) tick();
    #1;
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL gw_resp_early: got %b want 0", bus.resp_valid); end
    tick(); #1;
    n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL gw_resp_valid: got %b want 1", bus.resp_valid); end
    n_vec++; if (bus.resp_inst !== 32'h00100513) begin n_err++; $display("FAIL gw_resp_inst: got %h want 00100513", bus.resp_inst); end
    tick();
    bus.mem_gnt = 1'b0;
  endtask

  task automatic test_clear();
    we_snap = we_cnt; rv_snap = rv_cnt;
    bus.req_valid = 1'b1; bus.req_addr = 32'h1004;
    tick();
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    repeat (3) tick();
    #1;
    n_vec++; if (bus.mem_a !== 32'h1006) begin n_err++; $display("FAIL cl_mem_a: got %h want 00001006", bus.mem_a); end
    clr = 1'b1;
    tick();
    bus.req_valid = 1'b1; bus.mem_gnt = 1'b0;
    #1;
    n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL cl_mem_req: got %b want 0", bus.mem_req); end
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL cl_req_ready: got %b want 1", bus.req_ready); end
    tick();
    clr = 1'b0; bus.req_valid = 1'b0;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL cl_idle_ignore: got %b want 1", bus.req_ready); end
    repeat (8) tick();
    n_vec++; if (we_cnt !== we_snap) begin n_err++; $display("FAIL cl_no_we: got %0d writes want %0d", we_cnt, we_snap); end
    n_vec++; if (rv_cnt !== rv_snap) begin n_err++; $display("FAIL cl_no_resp: got %0d resps want %0d", rv_cnt, rv_snap); end
  endtask

  task automatic test_clear_done();
    bus.req_valid = 1'b1; bus.req_addr = 32'h1004;
    tick();
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    #1;
    n_vec++; if (bus.cache_we !== 1'b1) begin n_err++; $display("FAIL cd_cache_we: got %b want 1", bus.cache_we); end
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL cd_resp_valid: got %b want 0", bus.resp_valid); end
    n_vec++; if (bus.cache_data !== 32'h00100513) begin n_err++; $display("FAIL cd_cache_data: got %h want 00100513", bus.cache_data); end
    tick();
    clr = 1'b0; bus.mem_gnt = 1'b0;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL cd_idle: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_rdy_stall();
    we_snap = we_cnt;
    bus.req_valid = 1'b1; bus.req_addr = 32'h1004;
    tick();
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    tick(); #1;
    n_vec++; if (bus.mem_a !== 32'h1004) begin n_err++; $display("FAIL rs_mem_a0: got %h want 00001004", bus.mem_a); end
    tick(); #1;
    n_vec++; if (bus.mem_a !== 32'h1005) begin n_err++; $display("FAIL rs_mem_a1: got %h want 00001005", bus.mem_a); end
    rdy = 1'b0;
    tick(); #1;
    n_vec++; if (bus.mem_a !== 32'h1004) begin n_err++; $display("FAIL rs_restart_a: got %h want 00001004", bus.mem_a); end
    tick();
    rdy = 1'b1;
    #1;
    n_vec++; if (bus.mem_a !== 32'h1004) begin n_err++; $display("FAIL rs_resume_a: got %h want 00001004", bus.mem_a); end
    for (int k = 1; k < 4; k++) begin
      tick(); #1;
      n_vec++; if (bus.mem_a !== 32'h1004 + 32'(k)) begin n_err++; $display("FAIL rs_mem_a_seq%0d: got %h want %h", k, bus.mem_a, 32'h1004 + 32'(k)); end
    end
    tick();
    tick();
    rdy = 1'b0;
    #1;
    n_vec++; if (bus.cache_we !== 1'b0) begin n_err++; $display("FAIL rs_we_frozen: got %b want 0", bus.cache_we); end
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rs_resp_frozen: got %b want 0", bus.resp_valid); end
    tick();
    rdy = 1'b1;
    #1;
    n_vec++; if (bus.cache_we !== 1'b1) begin n_err++; $display("FAIL rs_we_deferred: got %b want 1", bus.cache_we); end
    n_vec++; if (bus.cache_data !== 32'h00100513) begin n_err++; $display("FAIL rs_cache_data: got %h want 00100513", bus.cache_data); end
    n_vec++; if (bus.resp_inst !== 32'h00100513) begin n_err++; $display("FAIL rs_resp_inst: got %h want 00100513", bus.resp_inst); end
    tick();
    bus.mem_gnt = 1'b0;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rs_idle: got %b want 1", bus.req_ready); end
    n_vec++; if (we_cnt !== we_snap + 1) begin n_err++; $display("FAIL rs_we_once: got %0d writes want %0d", we_cnt, we_snap + 1); end
  endtask

  task automatic test_reset_mid();
    we_snap = we_cnt;
    bus.req_valid = 1'b1; bus.req_addr = 32'h1004;
    tick();
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    repeat (2) tick();
    rst_in = 1'b0;
    #1;
    n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rm_mem_req: got %b want 0", bus.mem_req); end
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rm_req_ready: got %b want 1", bus.req_ready); end
    n_vec++; if (bus.mem_a !== 32'h0) begin n_err++; $display("FAIL rm_mem_a: got %h want 0", bus.mem_a); end
    n_vec++; if (bus.cache_data !== 32'h0) begin n_err++; $display("FAIL rm_cache_data: got %h want 0", bus.cache_data); end
    tick();
    rst_in = 1'b1; bus.mem_gnt = 1'b0;
    repeat (8) tick();
    n_vec++; if (we_cnt !== we_snap) begin n_err++; $display("FAIL rm_no_we: got %0d writes want %0d", we_cnt, we_snap); end
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rm_idle: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1'b1; bus.req_addr = 32'h2006;
    tick();
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      n_vec++; if (bus.mem_a !== 32'h2004 + 32'(k)) begin n_err++; $display("FAIL bb_mem_a%0d: got %h want %h", k, bus.mem_a, 32'h2004 + 32'(k)); end
    end
    tick();
    tick(); #1;
    n_vec++; if (bus.cache_addr !== 32'h2004) begin n_err++; $display("FAIL bb_cache_addr: got %h want 00002004", bus.cache_addr); end
    n_vec++; if (bus.cache_data !== 32'h82838081) begin n_err++; $display("FAIL bb_cache_data: got %h want 82838081", bus.cache_data); end
    n_vec++; if (bus.cache_we !== 1'b1) begin n_err++; $display("FAIL bb_cache_we: got %b want 1", bus.cache_we); end
    tick();
    bus.mem_gnt = 1'b0; bus.req_valid = 1'b1; bus.req_addr = 32'h1004;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bb_ready: got %b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    #1;
    n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL bb_accept: got %b want 1", bus.mem_req); end
    repeat (6) tick();
    #1;
    n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL bb_resp_valid: got %b want 1", bus.resp_valid); end
    n_vec++; if (bus.resp_inst !== 32'h00100513) begin n_err++; $display("FAIL bb_resp_inst: got %h want 00100513", bus.resp_inst); end
    tick();
    bus.mem_gnt = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; we_cnt = 0; rv_cnt = 0; we_snap = 0; rv_snap = 0;
    rdy = 1'b1; clr = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.mem_gnt = 1'b0;
    test_reset();
    test_immediate_grant();
    test_grant_wait();
    test_clear();
    test_clear_done();
    test_rdy_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
